// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and saturating stall/bubble statistics.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              main_vld, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, main_data_d;
  logic              skid_vld, skid_vld_d;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data, skid_data_d;

  logic in_fire;
  logic out_fire;

  // With the skid buffer, in_ready is a plain register output and never sees
  // out_ready; without it, a draining stage can accept in the same cycle.
  assign in_ready = HAS_SKID ? ~skid_vld : (~main_vld | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_vld & out_ready;

  // NOTE: every variable gets a hold value first, so no branch leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    main_vld_d  = main_vld;
    main_ctrl_d = main_ctrl;
    main_data_d = main_data;
    skid_vld_d  = skid_vld;
    skid_ctrl_d = skid_ctrl;
    skid_data_d = skid_data;

    if (flush) begin
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else if (skid_vld) begin
      // TWO: input is blocked; the skid entry moves up when the head leaves.
      if (out_ready) begin
        main_vld_d  = 1'b1;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
        skid_vld_d  = 1'b0;
        skid_ctrl_d = '0;
        skid_data_d = '0;
      end
    end else if (in_fire && (!main_vld || out_ready)) begin
      main_vld_d  = 1'b1;
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (in_fire && HAS_SKID) begin
      skid_vld_d  = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end else if (out_fire) begin
      // Zeroing on drain keeps out_ctrl a NOP whenever out_valid is low.
      main_vld_d  = 1'b0;
      main_ctrl_d = '0;
      main_data_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_vld  <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_vld  <= 1'b0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      main_vld  <= main_vld_d;
      main_ctrl <= main_ctrl_d;
      main_data <= main_data_d;
      skid_vld  <= skid_vld_d;
      skid_ctrl <= skid_ctrl_d;
      skid_data <= skid_data_d;
    end
  end

  assign out_valid = main_vld;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  logic stall_cyc;
  logic bubble_cyc;

  assign stall_cyc  = main_vld & ~out_ready;
  assign bubble_cyc = ~main_vld & out_ready;

  // Counters saturate at all-ones and keep running through flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_cyc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble_cyc && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register for the pipeline CPU. It supersedes the hard-wired per-stage registers: IF/ID, ID/EX, EX/MEM and MEM/WB all become instances.
- Carries an opaque payload split into a control field and a data field. The control field is forced to zero when the stage holds no valid instruction, which makes the stage a NOP bubble.
- Adds a valid/ready handshake that propagates a downstream stall without dropping data.
- Adds an optional 2-entry skid buffer, so that in_ready is driven from a register.
- Keeps flush and stall separate: flush kills the contents, stall holds them.
- Provides saturating stall and bubble counters for performance analysis.

Parameters:
- CTRL_W, 16: width of the control field (RegWrite, MemWrite, ALUop, ...); forced to 0 in a bubble.
- DATA_W, 128: width of the data field (operands, immediate, PC, register indices).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous kill of all stage contents (branch mispredict or jump).
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  control field of the offered entry.
- in_data  in  DATA_W  data field of the offered entry.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts the entry (0 = stall).
- out_ctrl  out  CTRL_W  control field; 0 whenever out_valid = 0.
- out_data  out  DATA_W  data field of the head entry; 0 when empty.
- stall_cnt  out  CNT_W  cycles with out_valid = 1 and out_ready = 0.
- bubble_cnt  out  CNT_W  cycles with out_valid = 0 and out_ready = 1.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage:
  - main entry: main_vld, main_ctrl, main_data. Drives the outputs.
  - skid entry: skid_vld, skid_ctrl, skid_data. Present only if SKID = 1.
- Reset (rst = 0, asynchronous): all valids, entries and counters go to 0. out_valid = 0, out_ctrl = 0, out_data = 0, stall_cnt = 0, bubble_cnt = 0.
  - in_ready = 1 after reset.
  - Reset asserted mid-transfer discards everything; no partial state survives.
- States are derived from the valid bits, not encoded separately:
  - EMPTY: main_vld = 0, skid_vld = 0.
  - ONE: main_vld = 1, skid_vld = 0.
  - TWO: main_vld = 1, skid_vld = 1.
- in_ready:
  - SKID = 1: in_ready = !skid_vld, registered; it does not depend on out_ready.
  - SKID = 0: in_ready = !main_vld | out_ready, combinational.
- Transitions when flush = 0:
  - EMPTY, in_fire: main loads the input → ONE.
  - ONE, in_fire and out_fire: main loads the input → ONE (back-to-back, 1 entry per cycle).
  - ONE, in_fire and no out_fire: SKID = 1 only; skid loads the input → TWO.
  - ONE, out_fire and no in_fire: → EMPTY; main ctrl and data are zeroed.
  - TWO: in_ready = 0. On out_fire, main takes the skid contents, skid clears → ONE. Otherwise hold.
  - No fire in any state: hold every entry bit-exact. This is a stall; the stage does not insert a bubble.
- Latency: 1 cycle from in_fire to out_valid. Ordering is strictly FIFO; no entry is lost or duplicated.
- flush = 1:
  - Next state is EMPTY; all entries are zeroed.
  - A same-cycle in_fire is dropped.
  - flush overrides a stall: entries are discarded even when out_ready = 0.
  - A same-cycle out_fire still counts as delivered downstream.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W − 1, with no wrap.
  - They are sampled on the current-cycle out_valid and out_ready, and keep counting during flush.
- The outputs are glitch-free registered values. The exception is the SKID = 0 in_ready path, which is combinational from out_ready.

Test Plan:
- Reset, then stream 5 entries (ctrl = 1..5, data = 0xA0..0xA4) with out_ready = 1. Required: each appears 1 cycle after its input, in order; in_ready stays 1; stall_cnt = 0.
- SKID = 1, load ctrl = 7, then hold out_ready = 0 for 4 cycles while offering ctrl = 8 and ctrl = 9. Required:
  - ctrl = 8 enters skid; in_ready falls to 0 the next cycle; ctrl = 9 is not accepted.
  - out_ctrl holds 7; stall_cnt = 4.
  - After releasing out_ready, the outputs are 7, 8, 9 in order.
- TWO state with flush = 1 and in_valid = 1 in the same cycle. Required: next cycle out_valid = 0, out_ctrl = 0, in_ready = 1; the offered entry never appears at the output.
- Idle with out_ready = 1 for 3 cycles. Required: bubble_cnt = 3, out_ctrl = 0. With CNT_W = 2, force 6 stall cycles: stall_cnt saturates at 3.
- SKID = 0, out_ready toggling 1, 0, 1, 0 with in_valid held at 1. Required: in_ready tracks !main_vld | out_ready combinationally; no entry is lost or duplicated over 8 entries.
- Drive rst = 0 asynchronously mid-cycle while in ONE. Required: out_valid, out_ctrl and the counters go to 0 immediately, without waiting for a clock edge.
